// File: rtl/keypad_pkg.sv
// Shared constants, debounce state type and key-code helper for the keypad scanner.
package keypad_pkg;

    localparam int NUM_COLS = 4;
    localparam int NUM_ROWS = 5;
    localparam int CODE_W   = 5;
    localparam int COL_W    = 2;

    localparam logic [CODE_W-1:0] CODE_NONE  = 5'd0;
    localparam logic [CODE_W-1:0] CODE_MULTI = 5'd31;

    typedef enum logic [1:0] {
        ST_RELEASED,
        ST_PRESS_DEB,
        ST_PRESSED,
        ST_RELEASE_DEB
    } deb_state_e;

    // Key at (row, col) is numbered row-major starting at 1 so that 0 can mean "no key".
    function automatic logic [CODE_W-1:0] key_code(input int row, input logic [COL_W-1:0] col);
        return CODE_W'(row * NUM_COLS) + CODE_W'(col) + CODE_W'(1);
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Debounce FSM: turns one scan result per full matrix scan into press/release events.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEB_SCANS = 3
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic [CODE_W-1:0] i_scan_result,
    input  logic              i_scan_strobe,
    output logic [CODE_W-1:0] o_key_code,
    output logic              o_key_valid,
    output logic              o_key_release,
    output logic              o_key_held
);

    localparam int CNT_W = $clog2(DEB_SCANS + 1);
    localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(DEB_SCANS);
    localparam bit SINGLE_SCAN = (DEB_SCANS == 1);

    deb_state_e        state_q, state_d;
    logic [CODE_W-1:0] cand_q, cand_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic [CNT_W-1:0]  deb_cnt_q, deb_cnt_d;
    logic              valid_q, valid_d;
    logic              release_q, release_d;

    logic [CODE_W-1:0] result_eff;
    logic [CNT_W-1:0]  cnt_inc;
    logic              cnt_done;

    // A scan with several keys down carries no usable key identity, so it counts as empty.
    always_comb begin
        result_eff = (i_scan_result == CODE_MULTI) ? CODE_NONE : i_scan_result;
        cnt_inc    = deb_cnt_q + CNT_W'(1);
        cnt_done   = (cnt_inc == CNT_TARGET);
    end

    // State and datapath registers.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q   <= ST_RELEASED;
            cand_q    <= CODE_NONE;
            code_q    <= CODE_NONE;
            deb_cnt_q <= '0;
            valid_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cand_q    <= cand_d;
            code_q    <= code_d;
            deb_cnt_q <= deb_cnt_d;
            valid_q   <= valid_d;
            release_q <= release_d;
        end
    end

    // Next-state decision, evaluated only when a fresh scan result arrives.
    always_comb begin
        state_d = state_q;
        if (i_scan_strobe) begin
            case (state_q)
                ST_RELEASED: begin
                    if (result_eff != CODE_NONE) begin
                        state_d = SINGLE_SCAN ? ST_PRESSED : ST_PRESS_DEB;
                    end
                end
                ST_PRESS_DEB: begin
                    if (result_eff == CODE_NONE) begin
                        state_d = ST_RELEASED;
                    end else if (result_eff == cand_q && cnt_done) begin
                        state_d = ST_PRESSED;
                    end
                end
                ST_PRESSED: begin
                    if (result_eff != code_q) begin
                        state_d = SINGLE_SCAN ? ST_RELEASED : ST_RELEASE_DEB;
                    end
                end
                ST_RELEASE_DEB: begin
                    if (result_eff == code_q) begin
                        state_d = ST_PRESSED;
                    end else if (cnt_done) begin
                        state_d = ST_RELEASED;
                    end
                end
                default: state_d = ST_RELEASED;
            endcase
        end
    end

    // Candidate tracking, counter and one-cycle event pulses.
    always_comb begin
        cand_d    = cand_q;
        code_d    = code_q;
        deb_cnt_d = deb_cnt_q;
        valid_d   = 1'b0;
        release_d = 1'b0;
        if (i_scan_strobe) begin
            case (state_q)
                ST_RELEASED: begin
                    if (result_eff != CODE_NONE) begin
                        cand_d    = result_eff;
                        deb_cnt_d = CNT_W'(1);
                        if (SINGLE_SCAN) begin
                            code_d  = result_eff;
                            valid_d = 1'b1;
                        end
                    end
                end
                ST_PRESS_DEB: begin
                    if (result_eff == CODE_NONE) begin
                        deb_cnt_d = '0;
                    end else if (result_eff == cand_q) begin
                        deb_cnt_d = cnt_inc;
                        if (cnt_done) begin
                            code_d  = cand_q;
                            valid_d = 1'b1;
                        end
                    end else begin
                        cand_d    = result_eff;
                        deb_cnt_d = CNT_W'(1);
                    end
                end
                ST_PRESSED: begin
                    if (result_eff != code_q) begin
                        deb_cnt_d = CNT_W'(1);
                        if (SINGLE_SCAN) begin
                            code_d    = CODE_NONE;
                            release_d = 1'b1;
                        end
                    end
                end
                ST_RELEASE_DEB: begin
                    if (result_eff == code_q) begin
                        deb_cnt_d = '0;
                    end else begin
                        deb_cnt_d = cnt_inc;
                        if (cnt_done) begin
                            code_d    = CODE_NONE;
                            release_d = 1'b1;
                        end
                    end
                end
                default: begin
                    deb_cnt_d = '0;
                end
            endcase
        end
    end

    // Held status is a pure decode of the debounce state.
    always_comb begin
        o_key_held = (state_q == ST_PRESSED) || (state_q == ST_RELEASE_DEB);
    end

    assign o_key_code    = code_q;
    assign o_key_valid   = valid_q;
    assign o_key_release = release_q;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Keypad matrix scanner: drives columns one-hot, samples synchronised rows, debounces the result.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV  = 10000,
    parameter int DEB_SCANS = 3
) (
    input  logic                i_clk,
    input  logic                i_rstn,
    input  logic [NUM_ROWS-1:0] i_key_in,
    output logic [NUM_COLS-1:0] o_key_out,
    output logic [CODE_W-1:0]   o_key_code,
    output logic                o_key_valid,
    output logic                o_key_release,
    output logic                o_key_held
);

    localparam int DWELL_W = $clog2(SCAN_DIV);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
    localparam logic [COL_W-1:0]   LAST_COL   = COL_W'(NUM_COLS - 1);

    logic [NUM_ROWS-1:0] rows_meta_q, rows_meta_d;
    logic [NUM_ROWS-1:0] rows_sync_q, rows_sync_d;
    logic [DWELL_W-1:0]  dwell_q, dwell_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [CODE_W-1:0]   acc_q, acc_d;
    logic [CODE_W-1:0]   scan_result_q, scan_result_d;
    logic                scan_strobe_q, scan_strobe_d;

    logic                sample;
    logic [2:0]          hit_cnt;
    logic [CODE_W-1:0]   hit_code;
    logic [CODE_W-1:0]   merged;

    // Decode the rows seen on the driven column into a hit count and a key code.
    always_comb begin
        hit_cnt  = '0;
        hit_code = CODE_NONE;
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (rows_sync_q[r]) begin
                hit_cnt  = hit_cnt + 3'd1;
                hit_code = key_code(r, col_q);
            end
        end
    end

    // Fold this column's hits into the running scan: one key anywhere keeps its code, more is MULTI.
    always_comb begin
        merged = acc_q;
        if (hit_cnt > 3'd1) begin
            merged = CODE_MULTI;
        end else if (hit_cnt == 3'd1) begin
            merged = (acc_q == CODE_NONE) ? hit_code : CODE_MULTI;
        end
    end

    // Column sequencing, sampling at the end of each dwell and publishing the result after column 3.
    always_comb begin
        rows_meta_d   = i_key_in;
        rows_sync_d   = rows_meta_q;
        sample        = (dwell_q == DWELL_LAST);
        dwell_d       = sample ? '0 : dwell_q + DWELL_W'(1);
        col_d         = sample ? col_q + COL_W'(1) : col_q;
        acc_d         = acc_q;
        scan_result_d = scan_result_q;
        scan_strobe_d = 1'b0;
        if (sample) begin
            if (col_q == LAST_COL) begin
                scan_result_d = merged;
                scan_strobe_d = 1'b1;
                acc_d         = CODE_NONE;
            end else begin
                acc_d = merged;
            end
        end
    end

    // Scanner registers, including the two-flop row synchroniser.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            rows_meta_q   <= '0;
            rows_sync_q   <= '0;
            dwell_q       <= '0;
            col_q         <= '0;
            acc_q         <= CODE_NONE;
            scan_result_q <= CODE_NONE;
            scan_strobe_q <= 1'b0;
        end else begin
            rows_meta_q   <= rows_meta_d;
            rows_sync_q   <= rows_sync_d;
            dwell_q       <= dwell_d;
            col_q         <= col_d;
            acc_q         <= acc_d;
            scan_result_q <= scan_result_d;
            scan_strobe_q <= scan_strobe_d;
        end
    end

    assign o_key_out = NUM_COLS'(1) << col_q;

    keypad_debounce #(
        .DEB_SCANS(DEB_SCANS)
    ) u_debounce (
        .i_clk         (i_clk),
        .i_rstn        (i_rstn),
        .i_scan_result (scan_result_q),
        .i_scan_strobe (scan_strobe_q),
        .o_key_code    (o_key_code),
        .o_key_valid   (o_key_valid),
        .o_key_release (o_key_release),
        .o_key_held    (o_key_held)
    );

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Testbench for keypad_scan_ctrl: key matrix model, scan-level reference model, scenario tasks.
module tb_keypad_scan_ctrl;

    localparam int SCAN_DIV  = 10;
    localparam int DEB_SCANS = 3;
    localparam int SCAN_CYC  = 4 * SCAN_DIV;
    localparam int MAX_SCANS = 64;
    // A result from the scan ending at cycle 40*(s+1) is visible after edge 40*s+41.
    localparam int EVT_OFS   = SCAN_CYC + 1;

    typedef struct {
        int         cyc;
        bit         rel;
        logic [4:0] code;
    } ev_t;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [4:0] key_in;
    logic [3:0] key_out;
    logic [4:0] key_code;
    logic       key_valid;
    logic       key_release;
    logic       key_held;
    logic [20:0] keys = '0;

    int  checks = 0;
    int  errors = 0;
    int  cyc;
    bit  mon_en = 1'b0;

    logic [20:0] plan     [0:MAX_SCANS-1];
    logic [4:0]  exp_code [0:MAX_SCANS-1];
    logic [4:0]  obs_code [0:MAX_SCANS-1];
    bit          exp_held [0:MAX_SCANS-1];
    bit          obs_held [0:MAX_SCANS-1];
    ev_t exp_ev[$];
    ev_t obs_ev[$];

    always #5 clk = ~clk;

    keypad_scan_ctrl #(
        .SCAN_DIV  (SCAN_DIV),
        .DEB_SCANS (DEB_SCANS)
    ) dut (
        .i_clk         (clk),
        .i_rstn        (rstn),
        .i_key_in      (key_in),
        .o_key_out     (key_out),
        .o_key_code    (key_code),
        .o_key_valid   (key_valid),
        .o_key_release (key_release),
        .o_key_held    (key_held)
    );

    // Key matrix: a pressed key k connects column (k-1)%4 to row (k-1)/4.
    always_comb begin
        key_in = '0;
        for (int k = 1; k <= 20; k++) begin
            if (keys[k] && key_out[(k-1) % 4]) key_in[(k-1) / 4] = 1'b1;
        end
    end

    // Cycles since reset release, used as the bench's own time base.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Record every cycle a pulse output is high.
    always @(negedge clk) begin
        if (mon_en) begin
            if (key_valid)   obs_ev.push_back('{cyc, 1'b0, key_code});
            if (key_release) obs_ev.push_back('{cyc, 1'b1, key_code});
        end
    end

    // Key code seen by a full scan of a stable key set: the sole key, otherwise nothing.
    function automatic logic [4:0] sole_key(input logic [20:0] m);
        int         n = 0;
        logic [4:0] c = '0;
        for (int k = 1; k <= 20; k++) begin
            if (m[k]) begin
                n++;
                c = 5'(k);
            end
        end
        return (n == 1) ? c : 5'd0;
    endfunction

    // Reference: a key is accepted after DEB_SCANS consecutive scans showing only it,
    // and released after DEB_SCANS consecutive scans not showing it.
    task automatic build_model(input int n);
        int         run_len = 0;
        int         miss = 0;
        logic [4:0] run_val = '0;
        logic [4:0] code = '0;
        bit         held = 1'b0;
        logic [4:0] eff;
        exp_ev.delete();
        for (int s = 0; s < n; s++) begin
            eff = sole_key(plan[s]);
            if (!held) begin
                if (eff == 5'd0)                         run_len = 0;
                else if (run_len > 0 && eff == run_val)  run_len++;
                else begin
                    run_val = eff;
                    run_len = 1;
                end
                if (run_len == DEB_SCANS) begin
                    held    = 1'b1;
                    code    = run_val;
                    miss    = 0;
                    run_len = 0;
                    exp_ev.push_back('{SCAN_CYC * s + EVT_OFS, 1'b0, code});
                end
            end else begin
                if (eff == code) miss = 0;
                else             miss++;
                if (miss == DEB_SCANS) begin
                    held    = 1'b0;
                    code    = 5'd0;
                    run_len = 0;
                    exp_ev.push_back('{SCAN_CYC * s + EVT_OFS, 1'b1, 5'd0});
                end
            end
            exp_code[s] = code;
            exp_held[s] = held;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        repeat (5) @(negedge clk);
        rstn = 1'b1;
    endtask

    // Apply plan[s] early in each scan and capture code/held once that scan has been judged.
    task automatic run_plan(input int n);
        obs_ev.delete();
        mon_en = 1'b1;
        for (int s = 0; s < n; s++) begin
            while (cyc < SCAN_CYC * s + 2) @(negedge clk);
            keys = plan[s];
            while (cyc < SCAN_CYC * s + EVT_OFS) @(negedge clk);
            obs_code[s] = key_code;
            obs_held[s] = key_held;
        end
        repeat (3) @(negedge clk);
        mon_en = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] exp_col;
        keys = '0;
        @(negedge clk);
        rstn = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (key_out !== 4'b0001 || key_code !== 5'd0 || key_valid !== 1'b0 ||
            key_release !== 1'b0 || key_held !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_values: out=%b code=%0d valid=%b rel=%b held=%b, expected 0001/0/0/0/0",
                     key_out, key_code, key_valid, key_release, key_held);
        end
        rstn = 1'b1;
        repeat (100) begin
            @(negedge clk);
            exp_col = 4'b0001 << ((cyc / SCAN_DIV) % 4);
            checks++;
            if (key_out !== exp_col) begin
                errors++;
                $display("[TB] FAIL column_step cycle %0d: got %b, expected %b", cyc, key_out, exp_col);
            end
        end
    endtask

    task automatic test_single_press();
        int n = 30;
        do_reset();
        for (int s = 0; s < n; s++) plan[s] = (s < 20) ? (21'd1 << 12) : '0;
        build_model(n);
        run_plan(n);
        for (int s = 0; s < n; s++) begin
            checks++;
            if (obs_code[s] !== exp_code[s] || obs_held[s] !== exp_held[s]) begin
                errors++;
                $display("[TB] FAIL single_state scan %0d: got code=%0d held=%b, expected code=%0d held=%b",
                         s, obs_code[s], obs_held[s], exp_code[s], exp_held[s]);
            end
        end
        checks++;
        if (obs_ev.size() !== exp_ev.size()) begin
            errors++;
            $display("[TB] FAIL single_events: got %0d pulses, expected %0d", obs_ev.size(), exp_ev.size());
        end
        for (int i = 0; i < obs_ev.size() && i < exp_ev.size(); i++) begin
            checks++;
            if (obs_ev[i].cyc !== exp_ev[i].cyc || obs_ev[i].rel !== exp_ev[i].rel || obs_ev[i].code !== exp_ev[i].code) begin
                errors++;
                $display("[TB] FAIL single_event %0d: got cyc=%0d rel=%b code=%0d, expected cyc=%0d rel=%b code=%0d",
                         i, obs_ev[i].cyc, obs_ev[i].rel, obs_ev[i].code, exp_ev[i].cyc, exp_ev[i].rel, exp_ev[i].code);
            end
        end
        if (obs_ev.size() > 0) begin
            checks++;
            if (obs_ev[0].rel !== 1'b0 || obs_ev[0].code !== 5'd12 || obs_ev[0].cyc - 2 > 4 * SCAN_CYC + 4) begin
                errors++;
                $display("[TB] FAIL single_latency: got code=%0d at cycle %0d, expected press 12 by cycle %0d",
                         obs_ev[0].code, obs_ev[0].cyc, 4 * SCAN_CYC + 6);
            end
        end
    endtask

    task automatic test_glitch();
        do_reset();
        obs_ev.delete();
        mon_en = 1'b1;
        while (cyc < 2) @(negedge clk);
        keys = 21'd1 << 7;
        while (cyc < 62) @(negedge clk);
        keys = '0;
        while (cyc < 400) @(negedge clk);
        mon_en = 1'b0;
        checks++;
        if (obs_ev.size() !== 0 || key_code !== 5'd0 || key_held !== 1'b0) begin
            errors++;
            $display("[TB] FAIL glitch: got %0d pulses code=%0d held=%b, expected 0 pulses code=0 held=0",
                     obs_ev.size(), key_code, key_held);
        end
    endtask

    task automatic test_sequence();
        int n = 50;
        int n_val = 0;
        int n_rel = 0;
        do_reset();
        for (int s = 0; s < n; s++) begin
            case (s / 10)
                0:       plan[s] = 21'd1 << 12;
                2:       plan[s] = 21'd1 << 13;
                4:       plan[s] = 21'd1 << 14;
                default: plan[s] = '0;
            endcase
        end
        build_model(n);
        run_plan(n);
        for (int s = 0; s < n; s++) begin
            checks++;
            if (obs_code[s] !== exp_code[s] || obs_held[s] !== exp_held[s]) begin
                errors++;
                $display("[TB] FAIL seq_state scan %0d: got code=%0d held=%b, expected code=%0d held=%b",
                         s, obs_code[s], obs_held[s], exp_code[s], exp_held[s]);
            end
        end
        for (int i = 0; i < obs_ev.size(); i++) begin
            if (obs_ev[i].rel) n_rel++;
            else               n_val++;
        end
        checks++;
        if (n_val !== 3 || n_rel !== 2 || obs_ev.size() !== exp_ev.size()) begin
            errors++;
            $display("[TB] FAIL seq_counts: got %0d valid %0d release, expected 3 valid 2 release", n_val, n_rel);
        end
        for (int i = 0; i < obs_ev.size() && i < exp_ev.size(); i++) begin
            checks++;
            if (obs_ev[i].cyc !== exp_ev[i].cyc || obs_ev[i].rel !== exp_ev[i].rel || obs_ev[i].code !== exp_ev[i].code) begin
                errors++;
                $display("[TB] FAIL seq_event %0d: got cyc=%0d rel=%b code=%0d, expected cyc=%0d rel=%b code=%0d",
                         i, obs_ev[i].cyc, obs_ev[i].rel, obs_ev[i].code, exp_ev[i].cyc, exp_ev[i].rel, exp_ev[i].code);
            end
        end
    endtask

    task automatic test_multi_key();
        int n = 30;
        do_reset();
        for (int s = 0; s < n; s++) begin
            if (s < 10)      plan[s] = 21'd1 << 8;
            else if (s < 20) plan[s] = (21'd1 << 8) | (21'd1 << 9);
            else             plan[s] = 21'd1 << 9;
        end
        build_model(n);
        run_plan(n);
        checks++;
        if (obs_ev.size() !== 3) begin
            errors++;
            $display("[TB] FAIL multi_count: got %0d pulses, expected 3", obs_ev.size());
        end else begin
            checks++;
            if (obs_ev[0].code !== 5'd8 || obs_ev[1].rel !== 1'b1 || obs_ev[1].cyc >= SCAN_CYC * 20 ||
                obs_ev[2].rel !== 1'b0 || obs_ev[2].code !== 5'd9) begin
                errors++;
                $display("[TB] FAIL multi_order: got %0d, rel@%0d, %0d; expected press 8, release in overlap, press 9",
                         obs_ev[0].code, obs_ev[1].cyc, obs_ev[2].code);
            end
        end
        for (int i = 0; i < obs_ev.size() && i < exp_ev.size(); i++) begin
            checks++;
            if (obs_ev[i].cyc !== exp_ev[i].cyc || obs_ev[i].rel !== exp_ev[i].rel || obs_ev[i].code !== exp_ev[i].code) begin
                errors++;
                $display("[TB] FAIL multi_event %0d: got cyc=%0d rel=%b code=%0d, expected cyc=%0d rel=%b code=%0d",
                         i, obs_ev[i].cyc, obs_ev[i].rel, obs_ev[i].code, exp_ev[i].cyc, exp_ev[i].rel, exp_ev[i].code);
            end
        end
    endtask

    task automatic test_reset_mid_press();
        do_reset();
        for (int s = 0; s < 8; s++) plan[s] = 21'd1 << 9;
        run_plan(8);
        checks++;
        if (key_held !== 1'b1 || key_code !== 5'd9) begin
            errors++;
            $display("[TB] FAIL midreset_pre: got held=%b code=%0d, expected held=1 code=9", key_held, key_code);
        end
        @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        checks++;
        if (key_out !== 4'b0001 || key_code !== 5'd0 || key_valid !== 1'b0 ||
            key_release !== 1'b0 || key_held !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_clear: out=%b code=%0d valid=%b rel=%b held=%b, expected 0001/0/0/0/0",
                     key_out, key_code, key_valid, key_release, key_held);
        end
        repeat (5) @(negedge clk);
        rstn = 1'b1;
        for (int s = 0; s < 6; s++) plan[s] = 21'd1 << 9;
        build_model(6);
        run_plan(6);
        checks++;
        if (obs_ev.size() !== exp_ev.size() || obs_ev.size() !== 1) begin
            errors++;
            $display("[TB] FAIL midreset_events: got %0d pulses, expected 1", obs_ev.size());
        end else begin
            checks++;
            if (obs_ev[0].cyc !== exp_ev[0].cyc || obs_ev[0].rel !== 1'b0 || obs_ev[0].code !== 5'd9) begin
                errors++;
                $display("[TB] FAIL midreset_repress: got cyc=%0d rel=%b code=%0d, expected cyc=%0d rel=0 code=9",
                         obs_ev[0].cyc, obs_ev[0].rel, obs_ev[0].code, exp_ev[0].cyc);
            end
        end
    endtask

    task automatic test_random();
        int n = 40;
        int s = 0;
        int len;
        int kind;
        logic [20:0] m;
        do_reset();
        while (s < n) begin
            kind = $urandom_range(0, 9);
            m = '0;
            if (kind >= 3) m[$urandom_range(1, 20)] = 1'b1;
            if (kind == 9)  m[$urandom_range(1, 20)] = 1'b1;
            len = $urandom_range(1, 6);
            for (int j = 0; j < len && s < n; j++) begin
                plan[s] = m;
                s++;
            end
        end
        build_model(n);
        run_plan(n);
        for (int k = 0; k < n; k++) begin
            checks++;
            if (obs_code[k] !== exp_code[k] || obs_held[k] !== exp_held[k]) begin
                errors++;
                $display("[TB] FAIL rand_state scan %0d: got code=%0d held=%b, expected code=%0d held=%b",
                         k, obs_code[k], obs_held[k], exp_code[k], exp_held[k]);
            end
        end
        checks++;
        if (obs_ev.size() !== exp_ev.size()) begin
            errors++;
            $display("[TB] FAIL rand_events: got %0d pulses, expected %0d", obs_ev.size(), exp_ev.size());
        end
        for (int i = 0; i < obs_ev.size() && i < exp_ev.size(); i++) begin
            checks++;
            if (obs_ev[i].cyc !== exp_ev[i].cyc || obs_ev[i].rel !== exp_ev[i].rel || obs_ev[i].code !== exp_ev[i].code) begin
                errors++;
                $display("[TB] FAIL rand_event %0d: got cyc=%0d rel=%b code=%0d, expected cyc=%0d rel=%b code=%0d",
                         i, obs_ev[i].cyc, obs_ev[i].rel, obs_ev[i].code, exp_ev[i].cyc, exp_ev[i].rel, exp_ev[i].code);
            end
        end
    endtask

    initial begin
        $display("[TB] keypad_scan_ctrl bench start");
        test_reset();
        test_single_press();
        test_glitch();
        test_sequence();
        test_multi_key();
        test_reset_mid_press();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
